rob_ctrl: RTL and testbench

ROB_CTRL -- requirements
Module: rob_ctrl

---
 rtl/rob_ctrl_pkg.sv | 32 +++
 rtl/rob_ctrl_if.sv | 48 ++++
 rtl/rob_ctrl.sv | 117 +++++++++++
 tb/tb_rob_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rob_ctrl_pkg.sv
// Shared types and constants for the reorder-buffer controller.
package rob_ctrl_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int IDX_W     = $clog2(ROB_DEPTH);

  // Index into the entry array, and pointer = index plus a wrap bit
  typedef logic [IDX_W-1:0] rob_idx_t;
  typedef logic [IDX_W:0]   rob_ptr_t;

  localparam logic [2:0] FU_LOAD  = 3'd6;
  localparam logic [2:0] FU_STORE = 3'd7;

  // One in-flight instruction; target holds the redirect pc reported at writeback
  typedef struct packed {
    logic        valid;
    logic        done;
    logic        mp;
    logic [31:0] pc;
    logic [6:0]  rdNew;
    logic [6:0]  rdOld;
    logic        isLoad;
    logic        isStore;
    logic [31:0] target;
  } rob_entry_t;

  // Pointer increment; the wrap bit toggles naturally on overflow of the index
  function automatic rob_ptr_t ptrInc(input rob_ptr_t p);
    return p + rob_ptr_t'(1);
  endfunction

endpackage

// File: rtl/rob_ctrl_if.sv
// Dispatch / writeback / commit / flush bundle between the pipeline and the ROB.
interface rob_ctrl_if;
  import rob_ctrl_pkg::*;

  logic        dispatch_valid;
  logic [31:0] DC_pc;
  logic [6:0]  DC_P_rd_new;
  logic [6:0]  DC_P_rd_old;
  logic [2:0]  DC_fu_sel;
  logic        rob_ready;
  rob_idx_t    DC_rob_idx;

  logic        wb_valid;
  rob_idx_t    wb_rob_idx;
  logic        wb_mispredict;
  logic [31:0] wb_redirect_pc;

  logic        commit_stall;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [6:0]  commit_P_rd_new;
  logic [6:0]  commit_P_rd_old;
  logic        commit_is_load;
  logic        commit_is_store;

  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        rob_empty;

  // Pipeline side: drives dispatch, writeback and stall; observes the ROB
  modport master (
    output dispatch_valid, DC_pc, DC_P_rd_new, DC_P_rd_old, DC_fu_sel,
    output wb_valid, wb_rob_idx, wb_mispredict, wb_redirect_pc, commit_stall,
    input  rob_ready, DC_rob_idx, commit_valid, commit_pc, commit_P_rd_new,
    input  commit_P_rd_old, commit_is_load, commit_is_store,
    input  mispredict, redirect_pc, rob_empty
  );

  // ROB side
  modport slave (
    input  dispatch_valid, DC_pc, DC_P_rd_new, DC_P_rd_old, DC_fu_sel,
    input  wb_valid, wb_rob_idx, wb_mispredict, wb_redirect_pc, commit_stall,
    output rob_ready, DC_rob_idx, commit_valid, commit_pc, commit_P_rd_new,
    output commit_P_rd_old, commit_is_load, commit_is_store,
    output mispredict, redirect_pc, rob_empty
  );

endinterface

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: in-order allocate, out-of-order completion,
// in-order retire, and full flush when a mispredicted entry retires.
module rob_ctrl
  import rob_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  rob_ctrl_if.slave  bus
);

  rob_entry_t robQ [ROB_DEPTH];
  rob_entry_t robD [ROB_DEPTH];
  rob_ptr_t   headQ, headD, tailQ, tailD;
  logic       mispredictQ, mispredictD;
  logic [31:0] redirectQ, redirectD;

  rob_idx_t   headIdx, tailIdx;
  rob_entry_t headEntry, newEntry;
  logic       full, empty, allocFire, commitFire;

  assign headIdx   = headQ[IDX_W-1:0];
  assign tailIdx   = tailQ[IDX_W-1:0];
  assign headEntry = robQ[headIdx];

  assign full  = (headIdx == tailIdx) && (headQ[IDX_W] != tailQ[IDX_W]);
  assign empty = (headQ == tailQ);

  // Nothing moves during the flush pulse cycle, so both fire signals are gated by it
  assign allocFire  = bus.dispatch_valid && !full && !mispredictQ;
  assign commitFire = headEntry.valid && headEntry.done && !bus.commit_stall && !mispredictQ;

  // Freshly dispatched entry; load/store flags are decoded from the FU class
  always_comb begin
    newEntry         = '0;
    newEntry.valid   = 1'b1;
    newEntry.pc      = bus.DC_pc;
    newEntry.rdNew   = bus.DC_P_rd_new;
    newEntry.rdOld   = bus.DC_P_rd_old;
    newEntry.isLoad  = (bus.DC_fu_sel == FU_LOAD);
    newEntry.isStore = (bus.DC_fu_sel == FU_STORE);
  end

  // Next state: writeback, then allocate, then retire; a mispredicted retire wipes everything
  always_comb begin
    robD        = robQ;
    headD       = headQ;
    tailD       = tailQ;
    mispredictD = 1'b0;
    redirectD   = redirectQ;
    if (!mispredictQ) begin
      if (bus.wb_valid && robQ[bus.wb_rob_idx].valid) begin
        robD[bus.wb_rob_idx].done   = 1'b1;
        robD[bus.wb_rob_idx].mp     = bus.wb_mispredict;
        robD[bus.wb_rob_idx].target = bus.wb_redirect_pc;
      end
      if (allocFire) begin
        robD[tailIdx] = newEntry;
        tailD         = ptrInc(tailQ);
      end
      if (commitFire) begin
        robD[headIdx] = '0;
        headD         = ptrInc(headQ);
        if (headEntry.mp) begin
          for (int i = 0; i < ROB_DEPTH; i++) begin
            robD[i] = '0;
          end
          tailD       = ptrInc(headQ);
          mispredictD = 1'b1;
          redirectD   = headEntry.target;
        end
      end
    end
  end

  // State register with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        robQ[i] <= '0;
      end
      headQ       <= '0;
      tailQ       <= '0;
      mispredictQ <= 1'b0;
      redirectQ   <= '0;
    end else begin
      robQ        <= robD;
      headQ       <= headD;
      tailQ       <= tailD;
      mispredictQ <= mispredictD;
      redirectQ   <= redirectD;
    end
  end

  assign bus.rob_ready   = !full;
  assign bus.rob_empty   = empty;
  assign bus.DC_rob_idx  = tailIdx;
  assign bus.mispredict  = mispredictQ;
  assign bus.redirect_pc = redirectQ;

  // Retire port shows the head entry only when it actually retires, zero otherwise
  always_comb begin
    bus.commit_valid    = commitFire;
    bus.commit_pc       = '0;
    bus.commit_P_rd_new = '0;
    bus.commit_P_rd_old = '0;
    bus.commit_is_load  = 1'b0;
    bus.commit_is_store = 1'b0;
    if (commitFire) begin
      bus.commit_pc       = headEntry.pc;
      bus.commit_P_rd_new = headEntry.rdNew;
      bus.commit_P_rd_old = headEntry.rdOld;
      bus.commit_is_load  = headEntry.isLoad;
      bus.commit_is_store = headEntry.isStore;
    end
  end

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed self-checking bench for rob_ctrl.
module tb_rob_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rob_ctrl_if bus();

  rob_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical register numbers are derived from the pc so expectations follow automatically
  function automatic logic [6:0] rdNewOf(input logic [31:0] pc);
    return pc[8:2];
  endfunction

  function automatic logic [6:0] rdOldOf(input logic [31:0] pc);
    return ~pc[8:2];
  endfunction

  task automatic applyStimulus(input logic dv, input logic [31:0] pc, input logic [2:0] fu,
                               input logic wbv, input logic [2:0] wbIdx, input logic wbMp,
                               input logic [31:0] wbPc, input logic stall);
    bus.dispatch_valid = dv;
    bus.DC_pc          = pc;
    bus.DC_P_rd_new    = rdNewOf(pc);
    bus.DC_P_rd_old    = rdOldOf(pc);
    bus.DC_fu_sel      = fu;
    bus.wb_valid       = wbv;
    bus.wb_rob_idx     = wbIdx;
    bus.wb_mispredict  = wbMp;
    bus.wb_redirect_pc = wbPc;
    bus.commit_stall   = stall;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 3'd0, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic dispatchOnly(input logic [31:0] pc, input logic [2:0] fu);
    applyStimulus(1'b1, pc, fu, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic wbOnly(input logic [2:0] idx, input logic mp, input logic [31:0] tgt);
    applyStimulus(1'b0, 32'h0, 3'd0, 1'b1, idx, mp, tgt, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkCommit(input string tag, input logic [31:0] pc,
                             input logic isLoad, input logic isStore);
    checkOutput({tag, "_valid"}, 32'(bus.commit_valid), 32'd1);
    checkOutput({tag, "_pc"}, bus.commit_pc, pc);
    checkOutput({tag, "_rdnew"}, 32'(bus.commit_P_rd_new), 32'(rdNewOf(pc)));
    checkOutput({tag, "_rdold"}, 32'(bus.commit_P_rd_old), 32'(rdOldOf(pc)));
    checkOutput({tag, "_ld"}, 32'(bus.commit_is_load), 32'(isLoad));
    checkOutput({tag, "_st"}, 32'(bus.commit_is_store), 32'(isStore));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_cv"}, 32'(bus.commit_valid), 32'd0);
    checkOutput({tag, "_cpc"}, bus.commit_pc, 32'd0);
  endtask

  initial begin
    logic [2:0] fu;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    idle();

    // Reset state
    #2;
    checkOutput("rst_ready", 32'(bus.rob_ready), 32'd1);
    checkOutput("rst_empty", 32'(bus.rob_empty), 32'd1);
    checkOutput("rst_idx", 32'(bus.DC_rob_idx), 32'd0);
    checkOutput("rst_mp", 32'(bus.mispredict), 32'd0);
    checkIdle("rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Fill all 8 entries; idx 3 is a load, idx 5 a store
    for (int i = 0; i < 8; i++) begin
      fu = (i == 3) ? 3'd6 : ((i == 5) ? 3'd7 : 3'd1);
      dispatchOnly(32'h1000 + 32'(4 * i), fu);
      #1;
      checkOutput($sformatf("fill_idx%0d", i), 32'(bus.DC_rob_idx), 32'(i));
      checkOutput($sformatf("fill_rdy%0d", i), 32'(bus.rob_ready), 32'd1);
      tick();
    end
    dispatchOnly(32'h2000, 3'd0);
    #1;
    checkOutput("full_ready", 32'(bus.rob_ready), 32'd0);
    checkOutput("full_empty", 32'(bus.rob_empty), 32'd0);
    tick();
    idle();
    #1;
    checkOutput("ninth_ignored_idx", 32'(bus.DC_rob_idx), 32'd0);
    checkOutput("ninth_ignored_rdy", 32'(bus.rob_ready), 32'd0);

    // Out-of-order writeback 3,1,0,2 retires 0,1,2,3 in order
    wbOnly(3'd3, 1'b0, 32'h0); #1; checkIdle("wb3"); tick();
    wbOnly(3'd1, 1'b0, 32'h0); #1; checkIdle("wb1"); tick();
    wbOnly(3'd0, 1'b0, 32'h0); #1; checkIdle("wb0_nobypass"); tick();
    wbOnly(3'd2, 1'b0, 32'h0); #1;
    checkCommit("c0", 32'h1000, 1'b0, 1'b0);
    checkOutput("c0_ready", 32'(bus.rob_ready), 32'd0);
    tick();
    idle(); #1;
    checkOutput("c1_ready", 32'(bus.rob_ready), 32'd1);
    checkCommit("c1", 32'h1004, 1'b0, 1'b0);
    tick();
    #1; checkCommit("c2", 32'h1008, 1'b0, 1'b0); tick();
    #1; checkCommit("c3", 32'h100C, 1'b1, 1'b0); tick();

    // Head done but stalled for three cycles
    wbOnly(3'd4, 1'b0, 32'h0); #1;
    checkIdle("head4_notdone");
    checkOutput("after_c3_idx", 32'(bus.DC_rob_idx), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 3'd0, 1'b0, 3'd0, 1'b0, 32'h0, 1'b1);
      #1;
      checkIdle($sformatf("stall%0d", i));
      tick();
    end
    idle(); #1; checkCommit("c4", 32'h1010, 1'b0, 1'b0); tick();
    wbOnly(3'd5, 1'b0, 32'h0); #1; checkIdle("head5_notdone"); tick();
    wbOnly(3'd6, 1'b0, 32'h0); #1; checkCommit("c5", 32'h1014, 1'b0, 1'b1); tick();
    wbOnly(3'd7, 1'b0, 32'h0); #1; checkCommit("c6", 32'h1018, 1'b0, 1'b0); tick();
    idle(); #1; checkCommit("c7", 32'h101C, 1'b0, 1'b0); tick();
    #1;
    checkOutput("drain_empty", 32'(bus.rob_empty), 32'd1);
    checkIdle("drain");

    // Mispredict on idx 2 flushes everything after it retires
    for (int i = 0; i < 6; i++) begin
      dispatchOnly(32'h3000 + 32'(4 * i), 3'd0);
      #1;
      checkOutput($sformatf("mp_fill_idx%0d", i), 32'(bus.DC_rob_idx), 32'(i));
      tick();
    end
    wbOnly(3'd2, 1'b1, 32'h0000_1040); #1; checkIdle("mp_wb2"); tick();
    wbOnly(3'd0, 1'b0, 32'h0); #1; checkIdle("mp_wb0"); tick();
    wbOnly(3'd1, 1'b0, 32'h0); #1; checkCommit("mp_c0", 32'h3000, 1'b0, 1'b0); tick();
    idle(); #1; checkCommit("mp_c1", 32'h3004, 1'b0, 1'b0); tick();
    dispatchOnly(32'h5000, 3'd0); #1;
    checkCommit("mp_c2", 32'h3008, 1'b0, 1'b0);
    checkOutput("mp_pre_pulse", 32'(bus.mispredict), 32'd0);
    tick();
    applyStimulus(1'b1, 32'h5004, 3'd0, 1'b1, 3'd3, 1'b0, 32'h0, 1'b0); #1;
    checkOutput("mp_pulse", 32'(bus.mispredict), 32'd1);
    checkOutput("mp_redirect", bus.redirect_pc, 32'h0000_1040);
    checkOutput("mp_empty", 32'(bus.rob_empty), 32'd1);
    checkOutput("mp_idx", 32'(bus.DC_rob_idx), 32'd3);
    checkIdle("mp_pulse");
    tick();
    idle(); #1;
    checkOutput("mp_pulse_end", 32'(bus.mispredict), 32'd0);
    checkOutput("mp_alloc_ignored", 32'(bus.rob_empty), 32'd1);
    checkOutput("mp_idx_after", 32'(bus.DC_rob_idx), 32'd3);

    // Steady allocate+retire across the index wrap
    dispatchOnly(32'h6000, 3'd0); #1;
    checkOutput("wrap_idx_e0", 32'(bus.DC_rob_idx), 32'd3);
    tick();
    applyStimulus(1'b1, 32'h6004, 3'd0, 1'b1, 3'd3, 1'b0, 32'h0, 1'b0); #1;
    checkOutput("wrap_idx_e1", 32'(bus.DC_rob_idx), 32'd4);
    checkIdle("wrap_e1");
    tick();
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 32'h6000 + 32'(4 * (k + 2)), 3'd0, 1'b1, 3'((4 + k) % 8),
                    1'b0, 32'h0, 1'b0);
      #1;
      checkOutput($sformatf("wrap_idx%0d", k), 32'(bus.DC_rob_idx), 32'((5 + k) % 8));
      checkOutput($sformatf("wrap_rdy%0d", k), 32'(bus.rob_ready), 32'd1);
      checkOutput($sformatf("wrap_emp%0d", k), 32'(bus.rob_empty), 32'd0);
      checkOutput($sformatf("wrap_cpc%0d", k), bus.commit_pc, 32'h6000 + 32'(4 * k));
      tick();
    end
    wbOnly(3'd0, 1'b0, 32'h0); #1; checkCommit("wrap_c12", 32'h6030, 1'b0, 1'b0); tick();
    idle(); #1; checkCommit("wrap_c13", 32'h6034, 1'b0, 1'b0); tick();
    #1;
    checkOutput("wrap_empty", 32'(bus.rob_empty), 32'd1);
    checkOutput("wrap_tail", 32'(bus.DC_rob_idx), 32'd1);

    // Asynchronous reset with five live entries and a retire pending
    for (int i = 0; i < 5; i++) begin
      dispatchOnly(32'h7000 + 32'(4 * i), 3'd0);
      tick();
    end
    wbOnly(3'd1, 1'b0, 32'h0); tick();
    idle(); #1;
    checkCommit("pre_rst", 32'h7000, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("arst_ready", 32'(bus.rob_ready), 32'd1);
    checkOutput("arst_empty", 32'(bus.rob_empty), 32'd1);
    checkOutput("arst_idx", 32'(bus.DC_rob_idx), 32'd0);
    checkOutput("arst_mp", 32'(bus.mispredict), 32'd0);
    checkOutput("arst_redirect", bus.redirect_pc, 32'd0);
    checkIdle("arst");
    checkOutput("arst_rdnew", 32'(bus.commit_P_rd_new), 32'd0);
    tick();
    checkIdle("arst_edge");
    rst = 1'b1;
    tick();
    checkOutput("post_rst_empty", 32'(bus.rob_empty), 32'd1);
    checkIdle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
